fpga_top: RTL and testbench
===========================

Name: fpga_top

Overview:
- Board-level top for a sequential unsigned integer divider with a multiplexed 4-digit, 7-segment hex display.
- A rising edge on start_in launches one restoring division of dividend_in by divisor_in; done flags a valid result.
- Quotient and remainder are latched and shown continuously on the display until the next result.

Parameters:
- DIVISOR_WIDTH, 8: divisor operand width.
- DIVIDEND_WIDTH, 8: dividend operand width; also the iteration count.
- REMAINDER_WIDTH, 8: remainder width; must equal DIVISOR_WIDTH.
- QUOTIENT_WIDTH, 8: quotient width; must equal DIVIDEND_WIDTH.
- CNT, 2000000: clock cycles per display digit slot (refresh divider); legal range 1..2^32-1.

Ports:
- clk, in, 1: single system clock, rising-edge.
- rst_in, in, 1: reset, asynchronous assert, active-low.
- start_in, in, 1: start request, level input (e.g. switch); an operation starts on its 0->1 transition.
- divisor_in, in, DIVISOR_WIDTH: divisor operand.
- dividend_in, in, DIVIDEND_WIDTH: dividend operand.
- done, out, 1: result valid.
- led_out, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- anode_act, out, 4: digit enables, active-low, one-hot-low.

Behaviour:
- Reset (rst_in=0, async): FSM=IDLE; done=0; quotient/remainder result registers=0; refresh counter=0; digit index=0; anode_act=4'b1110; led_out shows digit 0 of the zeroed result, i.e. 7'b1000000.
- start_in passes through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle start pulse.
  - Holding start_in high never retriggers.
  - A start pulse arriving during CALC is ignored.
- FSM IDLE/DONE -> LOAD on start pulse.
  - LOAD (1 cycle): capture divisor_in and dividend_in. Capture occurs 3 clock edges after start_in is first sampled high. Clear done and the partial remainder.
- CALC: restoring division, exactly DIVIDEND_WIDTH cycles, MSB first.
  - Shift {rem,quo} left by one.
  - If the shifted rem >= divisor: subtract divisor and set quo LSB to 1.
  - rem uses REMAINDER_WIDTH+1 bits internally.
- CALC -> DONE: write quotient/remainder result registers and set done=1.
  - done stays high until the next start pulse (cleared in LOAD) or reset.
  - Total latency from synchronized start pulse to done=1 is DIVIDEND_WIDTH+2 cycles.
- Divide by zero: quotient = all ones, remainder = dividend. This falls out of the restoring algorithm naturally; no special flag.
- Operand changes after LOAD do not affect the running or completed result.
- Display
  - Free-running refresh counter 0..CNT-1. On wrap, digit index (2 bits) increments, wrapping 3->0.
  - Digit 0 (anode_act=1110) = remainder[3:0].
  - Digit 1 (1101) = remainder[7:4].
  - Digit 2 (1011) = quotient[3:0].
  - Digit 3 (0111) = quotient[7:4].
  - Fields narrower than 8 bits are zero-extended; bits above 8 are not displayed.
- Hex font, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- During CALC the display keeps showing the previous result.
- Reset mid-operation: immediate return to reset state; the in-flight result is discarded.

Decomposition:
- Package fpga_top_pkg holds:
  - FSM state enum (IDLE, LOAD, CALC, DONE).
  - 16-entry seven-segment font constant.
  - Anode one-hot-low patterns.
  - Width-consistency rule (QUOTIENT_WIDTH==DIVIDEND_WIDTH, REMAINDER_WIDTH==DIVISOR_WIDTH).
- One sub-module, seq_divider: synchronizer-free restoring divider core with start/done, operands, and quotient/remainder outputs.
- The synchronizer, edge detect, result latch and display mux stay in fpga_top.

Test Plan:
- Reset held low 5 cycles -> done=0, anode_act=1110, led_out=1000000. Release; no start -> done stays 0.
- Raise start_in, then one cycle later dividend=0xF0, divisor=0x0F -> done=1 within 12 cycles; quotient 0x10, remainder 0x00. Digits 3..0 show 1,0,0,0 (led_out 1111001,1000000,1000000,1000000).
- Drop start_in, re-raise with dividend=0x45, divisor=0x08 applied one cycle later -> done drops, then re-asserts; quotient 0x08, remainder 0x05. Digit 0 shows 0010010, digit 2 shows 0000000.
- dividend=0x37, divisor=0x00 -> quotient 0xFF, remainder 0x37. Digit 3 shows 0001110.
- dividend=0x05, divisor=0x09 -> quotient 0x00, remainder 0x05. Holding start_in high 100 cycles causes no second LOAD.
- CNT=4 -> anode_act cycles 1110->1101->1011->0111->1110 every 4 clocks. Asserting reset mid-CALC clears done and the result within the same cycle.

Source files
------------

// File: rtl/fpga_top_pkg.sv
// Shared types and constants for the divider board top: FSM states,
// seven-segment font, digit-enable patterns and the operand width rule.
package fpga_top_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Active-low {g,f,e,d,c,b,a}, indexed by the hex digit value
   localparam logic [6:0] SEG_FONT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   localparam logic [3:0] ANODE_SEL [4] = '{
      4'b1110, 4'b1101, 4'b1011, 4'b0111
   };

   function automatic bit widths_ok(input int unsigned qw, input int unsigned ddw,
                                    input int unsigned rw, input int unsigned dsw);
      return (qw == ddw) && (rw == dsw);
   endfunction

endpackage

// File: rtl/fpga_top_seq_divider.sv
// Restoring unsigned divider core: one quotient bit per cycle, MSB first.
// fin_o pulses with the final quotient/remainder on quotient_o/remainder_o.
module seq_divider
   import fpga_top_pkg::*;
#(
   parameter int unsigned DIVISOR_WIDTH  = 8,
   parameter int unsigned DIVIDEND_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
   input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
   output logic                      done_o,
   output logic                      fin_o,
   output logic [DIVIDEND_WIDTH-1:0] quotient_o,
   output logic [DIVISOR_WIDTH-1:0]  remainder_o
);

   localparam int unsigned      CW   = $clog2(DIVIDEND_WIDTH + 1);
   localparam logic [CW-1:0]    LAST = CW'(DIVIDEND_WIDTH - 1);

   div_state_e                state_q, state_d;
   logic                      done_q, done_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      load, step;

   logic [DIVISOR_WIDTH-1:0]  dvs_q;
   logic [DIVISOR_WIDTH-1:0]  rem_q;
   logic [DIVIDEND_WIDTH-1:0] quo_q;
   logic [DIVISOR_WIDTH:0]    sh;
   logic                      ge;
   logic [DIVISOR_WIDTH-1:0]  rem_nxt;
   logic [DIVIDEND_WIDTH-1:0] quo_nxt;

   // The shifted partial remainder needs one extra bit before the compare
   always_comb begin
      sh      = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
      ge      = (sh >= {1'b0, dvs_q});
      rem_nxt = ge ? DIVISOR_WIDTH'(sh - {1'b0, dvs_q}) : sh[DIVISOR_WIDTH-1:0];
      quo_nxt = DIVIDEND_WIDTH'({quo_q, ge});
   end

   always_comb begin
      state_d = state_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      fin_o   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) state_d = LOAD;
         end
         LOAD: begin
            load    = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: begin
            step  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               fin_o   = 1'b1;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         dvs_q <= divisor_i;
         quo_q <= dividend_i;
         rem_q <= '0;
      end else if (step) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
      end
   end

   assign done_o      = done_q;
   assign quotient_o  = quo_nxt;
   assign remainder_o = rem_nxt;

endmodule

// File: rtl/fpga_top.sv
// Board top: synchronised start edge drives the sequential divider; the
// latched quotient/remainder is shown on a multiplexed 4-digit hex display.
module fpga_top
   import fpga_top_pkg::*;
#(
   parameter int unsigned DIVISOR_WIDTH   = 8,
   parameter int unsigned DIVIDEND_WIDTH  = 8,
   parameter int unsigned REMAINDER_WIDTH = 8,
   parameter int unsigned QUOTIENT_WIDTH  = 8,
   parameter int unsigned CNT             = 2000000
) (
   input  logic                      clk,
   input  logic                      rst_in,
   input  logic                      start_in,
   input  logic [DIVISOR_WIDTH-1:0]  divisor_in,
   input  logic [DIVIDEND_WIDTH-1:0] dividend_in,
   output logic                      done,
   output logic [6:0]                led_out,
   output logic [3:0]                anode_act
);

   if (!widths_ok(QUOTIENT_WIDTH, DIVIDEND_WIDTH, REMAINDER_WIDTH, DIVISOR_WIDTH)) begin : g_width_check
      $error("fpga_top: quotient/remainder widths must match dividend/divisor widths");
   end

   localparam logic [31:0] REFRESH_LAST = 32'(CNT - 1);

   logic                       start_s1_q, start_s2_q, start_s3_q;
   logic                       start_pulse;
   logic                       div_fin;
   logic [QUOTIENT_WIDTH-1:0]  div_quo;
   logic [REMAINDER_WIDTH-1:0] div_rem;
   logic [QUOTIENT_WIDTH-1:0]  quo_res_q;
   logic [REMAINDER_WIDTH-1:0] rem_res_q;
   logic [31:0]                refr_q;
   logic [1:0]                 digit_q;
   logic [7:0]                 quo8, rem8;
   logic [3:0]                 nib;

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         start_s3_q <= 1'b0;
      end else begin
         start_s1_q <= start_in;
         start_s2_q <= start_s1_q;
         start_s3_q <= start_s2_q;
      end
   end

   assign start_pulse = start_s2_q & ~start_s3_q;

   seq_divider #(
      .DIVISOR_WIDTH  (DIVISOR_WIDTH),
      .DIVIDEND_WIDTH (DIVIDEND_WIDTH)
   ) u_div (
      .clk         (clk),
      .rst_ni      (rst_in),
      .start_i     (start_pulse),
      .divisor_i   (divisor_in),
      .dividend_i  (dividend_in),
      .done_o      (done),
      .fin_o       (div_fin),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   // Display keeps the previous result until the core finishes the next one
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         quo_res_q <= '0;
         rem_res_q <= '0;
      end else if (div_fin) begin
         quo_res_q <= div_quo;
         rem_res_q <= div_rem;
      end
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         refr_q  <= '0;
         digit_q <= '0;
      end else if (refr_q == REFRESH_LAST) begin
         refr_q  <= '0;
         digit_q <= digit_q + 2'd1;
      end else begin
         refr_q  <= refr_q + 32'd1;
      end
   end

   assign quo8 = 8'(quo_res_q);
   assign rem8 = 8'(rem_res_q);

   always_comb begin
      nib = rem8[3:0];
      case (digit_q)
         2'd0: nib = rem8[3:0];
         2'd1: nib = rem8[7:4];
         2'd2: nib = quo8[3:0];
         2'd3: nib = quo8[7:4];
         default: nib = rem8[3:0];
      endcase
   end

   assign led_out   = SEG_FONT[nib];
   assign anode_act = ANODE_SEL[digit_q];

endmodule

// File: tb/tb_fpga_top.sv
// Self-checking bench for fpga_top: table vectors, random operands against
// an arithmetic reference, and hand-written start/reset corner sequences.
module tb_fpga_top;

   localparam int CNT = 4;

   logic       clk = 1'b0;
   logic       rst_in = 1'b0;
   logic       start_in = 1'b0;
   logic [7:0] divisor_in = 8'h00;
   logic [7:0] dividend_in = 8'h00;
   logic       done;
   logic [6:0] led_out;
   logic [3:0] anode_act;

   always #5 clk = ~clk;

   fpga_top #(.CNT(CNT)) dut (
      .clk         (clk),
      .rst_in      (rst_in),
      .start_in    (start_in),
      .divisor_in  (divisor_in),
      .dividend_in (dividend_in),
      .done        (done),
      .led_out     (led_out),
      .anode_act   (anode_act)
   );

   int total = 0;
   int bad   = 0;
   int ncyc;

   // Clock edges seen since reset release: drives the expected digit slot
   always @(posedge clk or negedge rst_in) begin
      if (!rst_in) ncyc <= 0;
      else         ncyc <= ncyc + 1;
   end

   logic [6:0] font_t [16];

   typedef struct {
      logic [7:0] dvd;
      logic [7:0] dvs;
      logic [7:0] q;
      logic [7:0] r;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
      if (b == 8'h00) return {8'hFF, a};
      return {8'(a / b), 8'(a % b)};
   endfunction

   task automatic check_disp(input string nm, input logic [7:0] q, input logic [7:0] r);
      int         d;
      logic [3:0] ea;
      logic [3:0] nb;
      for (int i = 0; i < 4 * CNT; i++) begin
         @(negedge clk);
         d  = (ncyc / CNT) % 4;
         ea = 4'b1111;
         ea[d] = 1'b0;
         case (d)
            0: nb = r[3:0];
            1: nb = r[7:4];
            2: nb = q[3:0];
            default: nb = q[7:4];
         endcase
         chk({nm, " anode"}, anode_act, ea);
         chk({nm, " led"}, led_out, font_t[nb]);
      end
   endtask

   // Raise start, present operands one cycle later, check exact done timing
   task automatic do_op(input logic [7:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] q, input logic [7:0] r, input string nm);
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      dividend_in = dvd;
      divisor_in  = dvs;
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk);
         if (k == 11) chk({nm, " done_before"}, done, 0);
         if (k == 12) chk({nm, " done_at_lat"}, done, 1);
      end
      check_disp(nm, q, r);
   endtask

   initial begin
      int         drops;
      logic [15:0] m;
      logic [7:0]  a, b;

      font_t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      vecs[0] = '{8'hF0, 8'h0F, 8'h10, 8'h00};
      vecs[1] = '{8'h45, 8'h08, 8'h08, 8'h05};
      vecs[2] = '{8'h37, 8'h00, 8'hFF, 8'h37};
      vecs[3] = '{8'h05, 8'h09, 8'h00, 8'h05};
      vecs[4] = '{8'hFF, 8'h01, 8'hFF, 8'h00};
      vecs[5] = '{8'hFF, 8'hFF, 8'h01, 8'h00};
      vecs[6] = '{8'h00, 8'h05, 8'h00, 8'h00};
      vecs[7] = '{8'h80, 8'h03, 8'h2A, 8'h02};

      // Reset state
      repeat (5) @(negedge clk);
      chk("reset done", done, 0);
      chk("reset anode", anode_act, 4'b1110);
      chk("reset led", led_out, 7'b1000000);
      rst_in = 1'b1;
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0) drops++;
      end
      chk("idle no done", drops, 0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
      end

      // Holding start high must not start another division
      do_op(8'h05, 8'h09, 8'h00, 8'h05, "hold");
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done !== 1'b1) drops++;
      end
      chk("hold no reload", drops, 0);

      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         m = ref_div(a, b);
         do_op(a, b, m[15:8], m[7:0], $sformatf("rnd%0d", i));
      end

      // Start re-raised during CALC and operands changed after capture
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      dividend_in = 8'h9C;
      divisor_in  = 8'h07;
      @(negedge clk);
      start_in = 1'b0;
      repeat (2) @(negedge clk);
      start_in    = 1'b1;
      dividend_in = 8'h11;
      divisor_in  = 8'h03;
      for (int k = 5; k <= 12; k++) begin
         @(negedge clk);
         if (k == 11) chk("calc_start done_before", done, 0);
         if (k == 12) chk("calc_start done_at_lat", done, 1);
      end
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done !== 1'b1) drops++;
      end
      chk("calc_start ignored", drops, 0);
      check_disp("calc_start", 8'h16, 8'h02);

      // Reset in the middle of CALC discards the in-flight result
      start_in = 1'b0;
      repeat (3) @(negedge clk);
      start_in = 1'b1;
      @(negedge clk);
      dividend_in = 8'h45;
      divisor_in  = 8'h08;
      repeat (6) @(negedge clk);
      #1;
      rst_in   = 1'b0;
      start_in = 1'b0;
      #1;
      chk("midcalc rst done", done, 0);
      chk("midcalc rst anode", anode_act, 4'b1110);
      chk("midcalc rst led", led_out, 7'b1000000);
      @(negedge clk);
      rst_in = 1'b1;
      drops = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done !== 1'b0) drops++;
      end
      chk("midcalc discarded", drops, 0);
      check_disp("post_rst", 8'h00, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
